// File: rtl/mux_lut_pkg.sv
// -----------------------------------------------------------------------------
// mux_lut_pkg
// Shared definitions for the mux_lut_gate block:
//   - 2-input truth-table constants, indexed by {a_bit, b_bit}
//   - out_state_e : occupancy state of the single output register
// -----------------------------------------------------------------------------
package mux_lut_pkg;

  // Bit k of a table is the output for {a_bit, b_bit} == k.
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

  // EMPTY: output register holds nothing; FULL: holds a result not yet taken.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

endpackage : mux_lut_pkg

// File: rtl/mux4_cell.sv
// -----------------------------------------------------------------------------
// mux4_cell
// One-bit 4:1 multiplexer; one instance per lane of mux_lut_gate.
// Ports:
//   sel [1:0] : select, {a_bit, b_bit}
//   d   [3:0] : data inputs (the truth-table bits)
//   o         : d[sel]
// -----------------------------------------------------------------------------
module mux4_cell (
  input  logic [1:0] sel,
  input  logic [3:0] d,
  output logic       o
);

  always_comb begin
    o = 1'b0;
    case (sel)
      2'd0:    o = d[0];
      2'd1:    o = d[1];
      2'd2:    o = d[2];
      default: o = d[3];
    endcase
  end

endmodule : mux4_cell

// File: rtl/mux_lut_gate.sv
// -----------------------------------------------------------------------------
// mux_lut_gate
// WIDTH independent lanes, each computing y[i] = tt[{a[i], b[i]}] through a
// 4:1 mux, with a programmable truth table and a one-deep registered output
// stage (1-cycle latency, full throughput under continuous flow).
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   cfg_we, cfg_tt  : truth-table write strobe / new table
//   in_valid/ready  : operand handshake; a, b operand vectors
//   out_valid/ready : result handshake; y registered result
//   tt              : current truth table
//   dbg_state       : output-stage occupancy state (EMPTY/FULL)
//   op_count        : output handshake count, saturating
//                     (only when MUX_LUT_GATE_CNT_EN is defined)
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// The source keeps valid and its data stable until that edge; ready may
// depend combinationally on the sink side (in_ready = !out_valid || out_ready).
// -----------------------------------------------------------------------------
module mux_lut_gate
  import mux_lut_pkg::*;
#(
  parameter int         WIDTH      = 8,
  parameter logic [3:0] DEFAULT_TT = TT_NAND
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_tt,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [3:0]       tt,
  output out_state_e       dbg_state
`ifdef MUX_LUT_GATE_CNT_EN
  ,
  output logic [15:0]      op_count
`endif
);

  out_state_e       state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [3:0]       tt_q, tt_d;
  logic [WIDTH-1:0] lut_y;
  logic             accept;

  // Lanes always read the registered table, so a beat accepted on the same
  // edge as a table write still sees the old table.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    mux4_cell u_cell (
      .sel ({a[i], b[i]}),
      .d   (tt_q),
      .o   (lut_y[i])
    );
  end

  assign in_ready = (state_q == ST_EMPTY) || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    tt_d    = tt_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (out_ready && !accept) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
    // y changes only on accept; a table write never touches a held result.
    if (accept) y_d = lut_y;
    if (cfg_we) tt_d = cfg_tt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      y_q     <= '0;
      tt_q    <= DEFAULT_TT;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      tt_q    <= tt_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign y         = y_q;
  assign tt        = tt_q;
  assign dbg_state = state_q;

`ifdef MUX_LUT_GATE_CNT_EN
  logic        out_hs;
  logic [15:0] cnt_q, cnt_d;

  assign out_hs = out_valid && out_ready;

  always_comb begin
    cnt_d = cnt_q;
    if (out_hs && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign op_count = cnt_q;
`endif

endmodule : mux_lut_gate
